// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of a byte-enabled data RAM port. It accepts one MIPS
//   load/store request at a time and presents the address, lane-replicated
//   write data, byte enables and write enable to the RAM for exactly one
//   ACCESS cycle. For loads it captures the RAM read data and sign- or
//   zero-extends it. It then returns a one-cycle response toward writeback.
//   Misaligned and illegal requests skip the RAM and respond one cycle after
//   they are accepted.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_opcode        MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   req_addr          effective byte address
//   req_store_data    rt value for stores
//   req_rd            destination tag, echoed on resp_rd
//   mem_*             RAM address/write_data/byte_enable/write_enable, mem_dout read data
//   resp_valid        one-cycle response pulse
//   resp_is_load      response belongs to a load
//   resp_rd           echoed tag
//   resp_data         extended load data (0 for stores and exceptions)
//   resp_exc          00 ok, 01 misaligned, 10 illegal opcode

module load_store_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter bit          ZERO_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_store_data,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_byte_enable,
    output logic              mem_write_enable,
    input  logic [31:0]       mem_dout,
    output logic              resp_valid,
    output logic              resp_is_load,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_exc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;

    // Decode of the incoming request
    logic        dec_legal;
    logic        dec_load;
    logic        dec_misaligned;
    logic [1:0]  dec_exc;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    always_comb begin
        dec_legal      = 1'b0;
        dec_load       = 1'b0;
        dec_misaligned = 1'b0;
        dec_exc        = 2'b00;
        dec_be         = '0;
        dec_wdata      = '0;

        case (req_opcode)
            6'b100000, 6'b100001, 6'b100011,
            6'b100100, 6'b100101: begin
                dec_legal = 1'b1;
                dec_load  = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase

        // opcode[1:0] encodes access size: 00 byte, 01 halfword, 11 word
        if (req_opcode[1:0] == 2'b01)
            dec_misaligned = req_addr[0];
        else if (req_opcode[1:0] == 2'b11)
            dec_misaligned = (req_addr[1:0] != 2'b00);

        if (!dec_legal)
            dec_exc = 2'b10;
        else if (dec_misaligned)
            dec_exc = 2'b01;

        if (dec_legal && !dec_load) begin
            case (req_opcode[1:0])
                2'b00: begin
                    dec_be    = 4'b0001 << req_addr[1:0];
                    dec_wdata = {4{req_store_data[7:0]}};
                end
                2'b01: begin
                    dec_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    dec_wdata = {2{req_store_data[15:0]}};
                end
                default: begin
                    dec_be    = 4'b1111;
                    dec_wdata = req_store_data;
                end
            endcase
        end
    end

    // Load result extraction from the RAM read data during ACCESS
    logic [31:0] lane;
    logic [31:0] load_data;

    always_comb begin
        lane      = mem_dout >> {lane_q, 3'b000};
        load_data = '0;
        case (op_q)
            6'b100000: load_data = {{24{lane[7]}}, lane[7:0]};
            6'b100001: load_data = {{16{lane[15]}}, lane[15:0]};
            6'b100011: load_data = mem_dout;
            6'b100100: load_data = {24'd0, lane[7:0]};
            6'b100101: load_data = {16'd0, lane[15:0]};
            default:   load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            op_q             <= '0;
            lane_q           <= '0;
            rd_q             <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_byte_enable  <= '0;
            mem_write_enable <= 1'b0;
            resp_valid       <= 1'b0;
            resp_is_load     <= 1'b0;
            resp_rd          <= '0;
            resp_data        <= '0;
            resp_exc         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_opcode;
                        lane_q    <= req_addr[1:0];
                        rd_q      <= req_rd;
                        req_ready <= 1'b0;
                        if (dec_exc != 2'b00) begin
                            // Exception: respond next cycle without touching the RAM
                            resp_valid   <= 1'b1;
                            resp_is_load <= dec_legal && dec_load;
                            resp_rd      <= req_rd;
                            resp_data    <= '0;
                            resp_exc     <= dec_exc;
                            state        <= RESP;
                        end else begin
                            // RAM-side outputs are registered here so they are
                            // valid for the whole ACCESS cycle
                            mem_address      <= req_addr;
                            mem_byte_enable  <= dec_be;
                            mem_write_data   <= dec_wdata;
                            mem_write_enable <= ~dec_load;
                            state            <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    resp_valid       <= 1'b1;
                    resp_is_load     <= ~op_q[3];
                    resp_rd          <= rd_q;
                    resp_data        <= load_data;
                    resp_exc         <= 2'b00;
                    mem_write_enable <= 1'b0;
                    if (ZERO_IDLE) begin
                        mem_address     <= '0;
                        mem_write_data  <= '0;
                        mem_byte_enable <= '0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid       <= 1'b0;
                    mem_write_enable <= 1'b0;
                    req_ready        <= 1'b1;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of directed load/store
// vectors against a small byte-enabled RAM model, plus hand-written
// sequences for reset during ACCESS and a held req_valid with two requests.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_store_data;
    logic [4:0]  req_rd;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_enable;
    logic [31:0] mem_dout;
    logic        resp_valid;
    logic        resp_is_load;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  resp_exc;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .ZERO_IDLE(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_opcode       (req_opcode),
        .req_addr         (req_addr),
        .req_store_data   (req_store_data),
        .req_rd           (req_rd),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_byte_enable  (mem_byte_enable),
        .mem_write_enable (mem_write_enable),
        .mem_dout         (mem_dout),
        .resp_valid       (resp_valid),
        .resp_is_load     (resp_is_load),
        .resp_rd          (resp_rd),
        .resp_data        (resp_data),
        .resp_exc         (resp_exc)
    );

    // Byte-enabled RAM: combinational read, write on the rising edge
    logic [31:0] ram [0:63];
    assign mem_dout = ram[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_write_enable)
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b])
                    ram[mem_address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end

    logic we_seen;
    always @(posedge clk) if (mem_write_enable) we_seen <= 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011,
                           LBU = 6'b100100, LHU = 6'b100101,
                           SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [1:0]  exc;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] data;
        logic        is_load;
    } vec_t;

    vec_t vecs [16];

    task automatic drive_req(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] sd, input logic [4:0] rd);
        req_valid      = 1'b1;
        req_opcode     = op;
        req_addr       = addr;
        req_store_data = sd;
        req_rd         = rd;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        we_seen   = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_opcode = '0; req_addr = '0; req_store_data = '0; req_rd = '0;

        //            op    addr   sd            rd     exc    be       wd            data          ld
        vecs[0]  = '{SW,  32'h10, 32'hDEADBEEF, 5'd1,  2'b00, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{LW,  32'h10, 32'h0,        5'd2,  2'b00, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b1};
        vecs[2]  = '{SB,  32'h13, 32'h000000A5, 5'd3,  2'b00, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[3]  = '{LB,  32'h13, 32'h0,        5'd4,  2'b00, 4'b0000, 32'h0,        32'hFFFFFFA5, 1'b1};
        vecs[4]  = '{LBU, 32'h13, 32'h0,        5'd5,  2'b00, 4'b0000, 32'h0,        32'h000000A5, 1'b1};
        vecs[5]  = '{SH,  32'h22, 32'h00008001, 5'd6,  2'b00, 4'b1100, 32'h80018001, 32'h0,        1'b0};
        vecs[6]  = '{LH,  32'h22, 32'h0,        5'd7,  2'b00, 4'b0000, 32'h0,        32'hFFFF8001, 1'b1};
        vecs[7]  = '{LHU, 32'h22, 32'h0,        5'd8,  2'b00, 4'b0000, 32'h0,        32'h00008001, 1'b1};
        vecs[8]  = '{LB,  32'h22, 32'h0,        5'd9,  2'b00, 4'b0000, 32'h0,        32'h00000001, 1'b1};
        vecs[9]  = '{LW,  32'h06, 32'h0,        5'd10, 2'b01, 4'b0000, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{SH,  32'h05, 32'h1234,     5'd11, 2'b01, 4'b0000, 32'h0,        32'h0,        1'b0};
        vecs[11] = '{6'b101111, 32'h06, 32'h0,  5'd12, 2'b10, 4'b0000, 32'h0,        32'h0,        1'b0};
        vecs[12] = '{SB,  32'h20, 32'h000001FF, 5'd13, 2'b00, 4'b0001, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[13] = '{LB,  32'h20, 32'h0,        5'd14, 2'b00, 4'b0000, 32'h0,        32'hFFFFFFFF, 1'b1};
        vecs[14] = '{SH,  32'h10, 32'hFFFF7F00, 5'd15, 2'b00, 4'b0011, 32'h7F007F00, 32'h0,        1'b0};
        vecs[15] = '{LH,  32'h12, 32'h0,        5'd16, 2'b00, 4'b0000, 32'h0,        32'hFFFFA5AD, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("reset_mem_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("reset_mem_addr", mem_address, 32'd0);
        chk("reset_resp_fields", {resp_data[29:0] | {23'd0, resp_rd, resp_exc}, resp_is_load, 1'b0}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            we_seen = 1'b0;
            drive_req(vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].rd);
            @(negedge clk);
            req_valid = 1'b0;
            if (vecs[i].exc != 2'b00) begin
                chk($sformatf("v%0d_exc_valid", i), {31'd0, resp_valid}, 32'd1);
                chk($sformatf("v%0d_exc", i), {30'd0, resp_exc}, {30'd0, vecs[i].exc});
                chk($sformatf("v%0d_exc_data", i), resp_data, 32'd0);
                chk($sformatf("v%0d_exc_rd", i), {27'd0, resp_rd}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d_exc_isload", i), {31'd0, resp_is_load}, {31'd0, vecs[i].is_load});
                chk($sformatf("v%0d_exc_be", i), {28'd0, mem_byte_enable}, 32'd0);
                @(negedge clk);
                chk($sformatf("v%0d_exc_no_we", i), {31'd0, we_seen}, 32'd0);
                chk($sformatf("v%0d_exc_ready", i), {31'd0, req_ready}, 32'd1);
            end else begin
                // ACCESS cycle
                chk($sformatf("v%0d_acc_addr", i), mem_address, vecs[i].addr);
                chk($sformatf("v%0d_acc_be", i), {28'd0, mem_byte_enable}, {28'd0, vecs[i].be});
                chk($sformatf("v%0d_acc_we", i), {31'd0, mem_write_enable}, {31'd0, ~vecs[i].is_load});
                if (!vecs[i].is_load)
                    chk($sformatf("v%0d_acc_wd", i), mem_write_data, vecs[i].wd);
                chk($sformatf("v%0d_acc_no_resp", i), {30'd0, resp_valid, req_ready}, 32'd0);
                // RESP cycle
                @(negedge clk);
                chk($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
                chk($sformatf("v%0d_resp_data", i), resp_data, vecs[i].data);
                chk($sformatf("v%0d_resp_exc", i), {30'd0, resp_exc}, 32'd0);
                chk($sformatf("v%0d_resp_rd", i), {27'd0, resp_rd}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d_resp_isload", i), {31'd0, resp_is_load}, {31'd0, vecs[i].is_load});
                chk($sformatf("v%0d_resp_we", i), {31'd0, mem_write_enable}, 32'd0);
                // Back in IDLE: pulse over, fields held
                @(negedge clk);
                chk($sformatf("v%0d_idle", i), {30'd0, resp_valid, req_ready}, 32'd1);
                chk($sformatf("v%0d_hold_data", i), resp_data, vecs[i].data);
            end
        end

        // Reset during ACCESS of a store: write completes, no response
        drive_req(SW, 32'h30, 32'h12345678, 5'd20);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstacc_we", {31'd0, mem_write_enable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstacc_ram", ram[12], 32'h12345678);
        chk("rstacc_ready", {31'd0, req_ready}, 32'd1);
        chk("rstacc_outputs", {mem_address | mem_write_data | {28'd0, mem_byte_enable} | resp_data},
            32'd0);
        chk("rstacc_flags", {24'd0, resp_rd, mem_write_enable, resp_valid, resp_is_load}, 32'd0);
        @(negedge clk);
        chk("rstacc_no_resp", {31'd0, resp_valid}, 32'd0);

        // Held req_valid with two queued LWs
        begin
            logic [31:0] q_addr [2];
            logic [4:0]  q_rd [2];
            int idx, accepts, pulses;
            int pulse_cyc [4];
            logic [4:0]  pulse_rd [4];
            logic [31:0] pulse_data [4];
            q_addr[0] = 32'h10; q_rd[0] = 5'd7;
            q_addr[1] = 32'h20; q_rd[1] = 5'd9;
            idx = 0; accepts = 0; pulses = 0;
            for (int k = 0; k < 9; k++) begin
                if (resp_valid && pulses < 4) begin
                    pulse_cyc[pulses]  = k;
                    pulse_rd[pulses]   = resp_rd;
                    pulse_data[pulses] = resp_data;
                    pulses++;
                end
                if (k < 6) drive_req(LW, q_addr[idx > 1 ? 1 : idx], 32'h0, q_rd[idx > 1 ? 1 : idx]);
                else req_valid = 1'b0;
                if (req_valid && req_ready) begin
                    idx++;
                    accepts++;
                end
                @(negedge clk);
            end
            req_valid = 1'b0;
            chk("held_accepts", accepts, 32'd2);
            chk("held_pulses", pulses, 32'd2);
            if (pulses >= 2) begin
                chk("held_pulse0_cyc", pulse_cyc[0], 32'd2);
                chk("held_pulse1_cyc", pulse_cyc[1], 32'd5);
                chk("held_pulse0_rd", {27'd0, pulse_rd[0]}, 32'd7);
                chk("held_pulse1_rd", {27'd0, pulse_rd[1]}, 32'd9);
                chk("held_pulse0_data", pulse_data[0], 32'hA5AD7F00);
                chk("held_pulse1_data", pulse_data[1], 32'h800100FF);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
